text_buf_ctrl: RTL and testbench

Command-driven controller for the 80x30 character RAM of the UART/VGA text editor. Accepts editing commands over a valid/ready handshake and maintains the cursor. Sequences all character RAM writes: single-cell put/erase, full-screen clear and one-line scroll. Owns the RAM read port and time-shares it with the VGA character fetch, stealing it for scroll reads only while video_on is low.

---
 rtl/text_buf_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_text_buf_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/text_buf_ctrl.sv
// Command-driven controller for the 80x30 character RAM: cursor tracking, single-cell edits,
// full-screen clear and one-line scroll that borrows the RAM read port during video blanking.
module text_buf_ctrl #(
  parameter int COLS   = 80,
  parameter int ROWS   = 30,
  parameter int ADDR_W = 12,
  parameter int DATA_W = 7
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_char,
  input  logic              video_on,
  input  logic [9:0]        pixel_x,
  input  logic [9:0]        pixel_y,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic [ADDR_W-1:0] ram_raddr,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [6:0]        cursor_x,
  output logic [4:0]        cursor_y,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, SCROLL_CP, SCROLL_CLR, CLEAR} state_t;

  localparam logic [6:0] X_LAST  = 7'(COLS - 1);
  localparam logic [4:0] Y_LAST  = 5'(ROWS - 1);
  localparam logic [2:0] OP_PUT  = 3'd0;
  localparam logic [2:0] OP_CR   = 3'd1;
  localparam logic [2:0] OP_BS   = 3'd2;
  localparam logic [2:0] OP_CLR  = 3'd3;
  localparam logic [2:0] OP_HOME = 3'd4;

  state_t state, state_n;

  logic [6:0]        cx_n, ptr_x, px_n, rd_dx, dx_n;
  logic [4:0]        cy_n, ptr_y, py_n, rd_dy, dy_n;
  logic              we_n, rd_valid, rd_valid_n, rd_done, rd_done_n, rd_issue, newline;
  logic [ADDR_W-1:0] waddr_n;
  logic [DATA_W-1:0] wdata_n;
  logic              unused_pixel_bits;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  // A scroll read is only launched while the display is blanked; otherwise VGA owns the port.
  assign rd_issue  = (state == SCROLL_CP) && !video_on && !rd_done;
  assign ram_raddr = rd_issue ? {ptr_y, ptr_x} : {pixel_y[8:4], pixel_x[9:3]};

  assign unused_pixel_bits = ^{pixel_x[2:0], pixel_y[9], pixel_y[3:0]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n    = state;
    cx_n       = cursor_x;
    cy_n       = cursor_y;
    we_n       = 1'b0;
    waddr_n    = ram_waddr;
    wdata_n    = ram_wdata;
    px_n       = ptr_x;
    py_n       = ptr_y;
    rd_valid_n = 1'b0;
    rd_done_n  = rd_done;
    dx_n       = rd_dx;
    dy_n       = rd_dy;
    newline    = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            OP_PUT: begin
              we_n    = 1'b1;
              waddr_n = {cursor_y, cursor_x};
              wdata_n = cmd_char;
              if (cursor_x == X_LAST) begin
                cx_n    = 7'd0;
                newline = 1'b1;
              end else begin
                cx_n = cursor_x + 7'd1;
              end
            end
            OP_CR: begin
              cx_n    = 7'd0;
              newline = 1'b1;
            end
            OP_BS: begin
              if (cursor_x != 7'd0) begin
                cx_n    = cursor_x - 7'd1;
                we_n    = 1'b1;
                waddr_n = {cursor_y, cursor_x - 7'd1};
                wdata_n = '0;
              end else if (cursor_y != 5'd0) begin
                cx_n    = X_LAST;
                cy_n    = cursor_y - 5'd1;
                we_n    = 1'b1;
                waddr_n = {cursor_y - 5'd1, X_LAST};
                wdata_n = '0;
              end
            end
            OP_CLR: begin
              state_n = CLEAR;
              px_n    = 7'd0;
              py_n    = 5'd0;
            end
            OP_HOME: begin
              cx_n = 7'd0;
              cy_n = 5'd0;
            end
            default: ;
          endcase
          // Newline on the bottom row keeps the cursor there and scrolls everything up.
          if (newline) begin
            if (cursor_y != Y_LAST) begin
              cy_n = cursor_y + 5'd1;
            end else begin
              state_n   = SCROLL_CP;
              px_n      = 7'd0;
              py_n      = 5'd1;
              rd_done_n = 1'b0;
            end
          end
        end
      end
      SCROLL_CP: begin
        if (rd_valid) begin
          we_n    = 1'b1;
          waddr_n = {rd_dy, rd_dx};
          wdata_n = ram_rdata;
        end
        if (rd_issue) begin
          rd_valid_n = 1'b1;
          dx_n       = ptr_x;
          dy_n       = ptr_y - 5'd1;
          if (ptr_x == X_LAST) begin
            px_n = 7'd0;
            if (ptr_y == Y_LAST) rd_done_n = 1'b1;
            else                 py_n = ptr_y + 5'd1;
          end else begin
            px_n = ptr_x + 7'd1;
          end
        end else if (rd_done && !rd_valid) begin
          state_n = SCROLL_CLR;
          px_n    = 7'd0;
        end
      end
      SCROLL_CLR: begin
        we_n    = 1'b1;
        waddr_n = {Y_LAST, ptr_x};
        wdata_n = '0;
        if (ptr_x == X_LAST) begin
          state_n = IDLE;
          cx_n    = 7'd0;
          cy_n    = Y_LAST;
        end else begin
          px_n = ptr_x + 7'd1;
        end
      end
      CLEAR: begin
        we_n    = 1'b1;
        waddr_n = {ptr_y, ptr_x};
        wdata_n = '0;
        if (ptr_x == X_LAST) begin
          px_n = 7'd0;
          if (ptr_y == Y_LAST) begin
            state_n = IDLE;
            cx_n    = 7'd0;
            cy_n    = 5'd0;
          end else begin
            py_n = ptr_y + 5'd1;
          end
        end else begin
          px_n = ptr_x + 7'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cursor_x  <= 7'd0;
      cursor_y  <= 5'd0;
      ram_we    <= 1'b0;
      ram_waddr <= '0;
      ram_wdata <= '0;
      ptr_x     <= 7'd0;
      ptr_y     <= 5'd0;
      rd_valid  <= 1'b0;
      rd_done   <= 1'b0;
      rd_dx     <= 7'd0;
      rd_dy     <= 5'd0;
    end else begin
      cursor_x  <= cx_n;
      cursor_y  <= cy_n;
      ram_we    <= we_n;
      ram_waddr <= waddr_n;
      ram_wdata <= wdata_n;
      ptr_x     <= px_n;
      ptr_y     <= py_n;
      rd_valid  <= rd_valid_n;
      rd_done   <= rd_done_n;
      rd_dx     <= dx_n;
      rd_dy     <= dy_n;
    end
  end

endmodule

// File: tb/tb_text_buf_ctrl.sv
// Directed bench for text_buf_ctrl: a cursor/RAM model fills a write scoreboard that is
// drained as the controller writes into a behavioural character RAM.
module tb_text_buf_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_op = 3'd0;
  logic [6:0] cmd_char = 7'd0;
  logic       video_on = 1'b0;
  logic [9:0] pixel_x = 10'd0;
  logic [9:0] pixel_y = 10'd0;
  logic       ram_we;
  logic [11:0] ram_waddr;
  logic [6:0] ram_wdata;
  logic [11:0] ram_raddr;
  logic [6:0] ram_rdata = 7'd0;
  logic [6:0] cursor_x;
  logic [4:0] cursor_y;
  logic       busy;

  logic [6:0]  mem    [0:4095];
  logic [6:0]  shadow [0:4095];
  logic        preload = 1'b0;
  logic [6:0]  preload_seed = 7'd0;
  logic [18:0] sb [$];
  int n_checks = 0;
  int n_pass = 0;
  int n_fail = 0;
  int viol = 0;
  int mx = 0;
  int my = 0;

  always #5 clk = ~clk;

  text_buf_ctrl dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_char(cmd_char), .video_on(video_on), .pixel_x(pixel_x),
    .pixel_y(pixel_y), .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
    .ram_raddr(ram_raddr), .ram_rdata(ram_rdata), .cursor_x(cursor_x),
    .cursor_y(cursor_y), .busy(busy)
  );

  function automatic logic [6:0] pat(input logic [6:0] seed, input int a);
    return 7'(a * 37) ^ seed ^ 7'(a >> 7);
  endfunction

  // Write-first synchronous RAM with one-cycle read latency.
  always @(posedge clk) begin
    if (preload) begin
      for (int a = 0; a < 4096; a++) mem[a] = pat(preload_seed, a);
    end else if (ram_we) begin
      mem[ram_waddr] = ram_wdata;
    end
    ram_rdata <= mem[ram_raddr];
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_wr(input int y, input int x, input logic [6:0] d);
    sb.push_back({5'(y), 7'(x), d});
    shadow[y * 128 + x] = d;
  endtask

  task automatic model_newline();
    if (my < 29) begin
      my++;
    end else begin
      for (int r = 1; r < 30; r++)
        for (int x = 0; x < 80; x++) push_wr(r - 1, x, shadow[r * 128 + x]);
      for (int x = 0; x < 80; x++) push_wr(29, x, 7'd0);
    end
  endtask

  task automatic model_cmd(input logic [2:0] op, input logic [6:0] ch);
    case (op)
      3'd0: begin
        push_wr(my, mx, ch);
        if (mx == 79) begin mx = 0; model_newline(); end
        else mx++;
      end
      3'd1: begin mx = 0; model_newline(); end
      3'd2: begin
        if (mx > 0) begin mx--; push_wr(my, mx, 7'd0); end
        else if (my > 0) begin mx = 79; my--; push_wr(my, mx, 7'd0); end
      end
      3'd3: begin
        for (int y = 0; y < 30; y++)
          for (int x = 0; x < 80; x++) push_wr(y, x, 7'd0);
        mx = 0; my = 0;
      end
      3'd4: begin mx = 0; my = 0; end
      default: ;
    endcase
  endtask

  task automatic sample_cycle();
    logic [18:0] exp;
    if (!reset_n) return;
    if (video_on && ram_raddr !== {pixel_y[8:4], pixel_x[9:3]}) viol++;
    if (ram_we) begin
      if (sb.size() == 0) begin
        check_output("unexpected_write", 32'(ram_we), 32'd0);
      end else begin
        exp = sb.pop_front();
        check_output("write", 32'({ram_waddr, ram_wdata}), 32'(exp));
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    sample_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [2:0] op, input logic [6:0] ch);
    int guard = 0;
    while (!cmd_ready && guard < 30000) begin tick(); guard++; end
    if (!cmd_ready) check_output("ready_wait", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_char  = ch;
    model_cmd(op, ch);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input bit toggle);
    int cyc = 0;
    while ((busy || sb.size() != 0) && cyc < 20000) begin
      if (toggle) begin
        video_on = 1'($urandom_range(0, 1));
        pixel_x  = 10'($urandom);
        pixel_y  = 10'($urandom);
      end
      tick();
      cyc++;
    end
    video_on = 1'b0;
    check_output("busy_done", 32'(busy), 32'd0);
    check_output("sb_drained", 32'(sb.size()), 32'd0);
  endtask

  task automatic load_ram(input logic [6:0] seed);
    repeat (3) tick();
    for (int a = 0; a < 4096; a++) shadow[a] = pat(seed, a);
    preload_seed = seed;
    preload = 1'b1;
    tick();
    preload = 1'b0;
  endtask

  task automatic compare_ram(input string tag);
    int mism = 0;
    for (int y = 0; y < 30; y++)
      for (int x = 0; x < 80; x++)
        if (mem[y * 128 + x] !== shadow[y * 128 + x]) mism++;
    check_output(tag, 32'(mism), 32'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    check_output("reset_outputs", 32'({ram_we, ram_waddr, ram_wdata, busy, cursor_x, cursor_y}), 32'd0);
    check_output("reset_ready", 32'(cmd_ready), 32'd1);

    $display("[TB] single PUT");
    apply_stimulus(3'd0, 7'h41);
    check_output("put_we", 32'(ram_we), 32'd1);
    check_output("put_addr_data", 32'({ram_waddr, ram_wdata}), 32'h00041);
    check_output("put_cursor", 32'({cursor_x, cursor_y}), 32'({7'd1, 5'd0}));

    $display("[TB] full row of PUTs");
    begin
      int drops = 0;
      apply_stimulus(3'd4, 7'd0);
      for (int i = 0; i < 80; i++) begin
        apply_stimulus(3'd0, 7'(8'h20 + i));
        if (cmd_ready !== 1'b1) drops++;
      end
      check_output("ready_during_puts", 32'(drops), 32'd0);
    end
    check_output("row_cursor", 32'({cursor_x, cursor_y}), 32'({7'd0, 5'd1}));

    $display("[TB] backspace");
    apply_stimulus(3'd2, 7'd0);
    check_output("bs_wrap_cursor", 32'({cursor_x, cursor_y}), 32'({7'd79, 5'd0}));
    apply_stimulus(3'd4, 7'd0);
    apply_stimulus(3'd2, 7'd0);
    apply_stimulus(3'd6, 7'h7F);
    repeat (3) tick();
    check_output("bs_origin_cursor", 32'({cursor_x, cursor_y}), 32'd0);
    check_output("bs_origin_sb", 32'(sb.size()), 32'd0);

    $display("[TB] scroll with video blanked");
    apply_stimulus(3'd4, 7'd0);
    for (int i = 0; i < 29; i++) apply_stimulus(3'd1, 7'd0);
    for (int i = 0; i < 5; i++) apply_stimulus(3'd0, 7'(8'h61 + i));
    check_output("pre_scroll_cursor", 32'({cursor_x, cursor_y}), 32'({7'd5, 5'd29}));
    load_ram(7'h15);
    apply_stimulus(3'd1, 7'd0);
    check_output("scroll_busy", 32'({busy, cmd_ready}), 32'b10);
    check_output("scroll_first_raddr", 32'(ram_raddr), 32'h080);
    wait_idle(1'b0);
    check_output("scroll_cursor", 32'({cursor_x, cursor_y}), 32'({7'd0, 5'd29}));
    compare_ram("scroll_ram");

    $display("[TB] scroll with video toggling");
    load_ram(7'h5A);
    viol = 0;
    apply_stimulus(3'd1, 7'd0);
    wait_idle(1'b1);
    check_output("scroll_port_conflicts", 32'(viol), 32'd0);
    check_output("scroll2_cursor", 32'({cursor_x, cursor_y}), 32'({7'd0, 5'd29}));
    compare_ram("scroll2_ram");

    $display("[TB] clear screen");
    load_ram(7'h33);
    apply_stimulus(3'd3, 7'd0);
    check_output("clr_busy", 32'({busy, cmd_ready}), 32'b10);
    wait_idle(1'b0);
    check_output("clr_cursor", 32'({cursor_x, cursor_y}), 32'd0);
    compare_ram("clr_ram");

    $display("[TB] reset during clear");
    apply_stimulus(3'd0, 7'h55);
    apply_stimulus(3'd3, 7'd0);
    repeat (300) tick();
    check_output("midclr_busy", 32'(busy), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check_output("midclr_reset_outputs", 32'({ram_we, ram_waddr, ram_wdata, busy, cursor_x, cursor_y}), 32'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    sb.delete();
    mx = 0;
    my = 0;
    check_output("midclr_ready", 32'(cmd_ready), 32'd1);
    repeat (5) tick();
    check_output("midclr_idle", 32'({busy, ram_we}), 32'd0);

    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
